// File: rtl/sddac_osr.sv
// Oversampling 1-bit sigma-delta DAC core: 1-deep sample buffer, OSR tick
// counter, 1st/2nd-order saturating modulator with optional LFSR dither.
// Ports: clk, rst (async, active-high), en (tick enable),
//        in_valid/in_data/in_ready (sample handshake), sd_out (1 = +FS),
//        clr_flags, overload (sticky saturation), underrun (sticky starvation).
module sddac_osr #(
    parameter int IN_W      = 16,
    parameter int ORDER     = 2,
    parameter int OSR       = 64,
    parameter int DITHER_EN = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            in_valid,
    input  logic [IN_W-1:0] in_data,
    output logic            in_ready,
    output logic            sd_out,
    input  logic            clr_flags,
    output logic            overload,
    output logic            underrun
);

    localparam int CW = (OSR > 1) ? $clog2(OSR) : 1;
    localparam int W1 = IN_W + 2;
    localparam int W2 = IN_W + 4;
    // Wide enough that no intermediate sum can wrap before saturation.
    localparam int SW = IN_W + 6;

    localparam logic [CW-1:0] LAST = CW'(OSR - 1);
    localparam logic signed [SW-1:0] FS_W  = SW'(1 <<< (IN_W - 1));
    localparam logic signed [SW-1:0] ONE_W = SW'(1);
    localparam logic [W1-1:0] S1_MAX = {1'b0, {(W1-1){1'b1}}};
    localparam logic [W1-1:0] S1_MIN = {1'b1, {(W1-1){1'b0}}};
    localparam logic [W2-1:0] S2_MAX = {1'b0, {(W2-1){1'b1}}};
    localparam logic [W2-1:0] S2_MIN = {1'b1, {(W2-1){1'b0}}};
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    logic [CW-1:0]   osr_cnt;
    logic            buf_full;
    logic [IN_W-1:0] buf_data;
    logic [IN_W-1:0] cur_sample;
    logic [W1-1:0]   s1;
    logic [W2-1:0]   s2;
    logic [15:0]     lfsr;

    logic consume;
    logic accept;
    logic q;
    logic lfsr_fb;

    logic signed [SW-1:0] s1_ext, s2_ext, x_w, fb_w, dith_w;
    logic signed [SW-1:0] sum1, sum2;
    logic [SW-W1:0]       hi1;
    logic [SW-W2:0]       hi2;
    logic                 clip1, clip2;
    logic [W1-1:0]        s1_nxt;
    logic [W2-1:0]        s2_nxt;

    assign consume  = en && (osr_cnt == LAST);
    assign in_ready = !buf_full || consume;
    assign accept   = in_valid && in_ready;

    // Quantiser looks at the last stage's current sign.
    assign q = (ORDER == 2) ? ~s2[W2-1] : ~s1[W1-1];

    // Taps 16,14,13,11 of the Fibonacci form map to bits 0,2,3,5.
    assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    always_comb begin
        s1_ext = {{(SW-W1){s1[W1-1]}}, s1};
        s2_ext = {{(SW-W2){s2[W2-1]}}, s2};
        fb_w   = q ? FS_W : -FS_W;
        dith_w = '0;
        if (DITHER_EN != 0) begin
            dith_w = lfsr[0] ? ONE_W : -ONE_W;
        end
        x_w  = {{(SW-IN_W){cur_sample[IN_W-1]}}, cur_sample};
        x_w  = x_w + dith_w;
        sum1 = s1_ext + x_w - fb_w;
        sum2 = s2_ext + s1_ext - (fb_w <<< 1);

        // Out of range when the bits above the integrator's sign disagree.
        hi1   = sum1[SW-1:W1-1];
        hi2   = sum2[SW-1:W2-1];
        clip1 = !((&hi1) || !(|hi1));
        clip2 = !((&hi2) || !(|hi2)) && (ORDER == 2);

        s1_nxt = sum1[W1-1:0];
        if (clip1) begin
            s1_nxt = sum1[SW-1] ? S1_MIN : S1_MAX;
        end
        s2_nxt = '0;
        if (ORDER == 2) begin
            s2_nxt = sum2[W2-1:0];
            if (clip2) begin
                s2_nxt = sum2[SW-1] ? S2_MIN : S2_MAX;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            osr_cnt    <= '0;
            buf_full   <= 1'b0;
            buf_data   <= '0;
            cur_sample <= '0;
            s1         <= '0;
            s2         <= '0;
            lfsr       <= LFSR_SEED;
            sd_out     <= 1'b0;
            overload   <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            if (accept) begin
                buf_full <= 1'b1;
                buf_data <= in_data;
            end else if (consume) begin
                buf_full <= 1'b0;
            end

            if (consume && buf_full) begin
                cur_sample <= buf_data;
            end

            if (en) begin
                osr_cnt <= (osr_cnt == LAST) ? '0 : osr_cnt + CW'(1);
                s1      <= s1_nxt;
                s2      <= s2_nxt;
                lfsr    <= {lfsr_fb, lfsr[15:1]};
                sd_out  <= q;
            end

            // A new event in the same cycle beats the clear.
            overload <= (en && (clip1 || clip2)) || (overload && !clr_flags);
            underrun <= (consume && !buf_full) || (underrun && !clr_flags);
        end
    end

endmodule

// File: tb/tb_sddac_osr.sv
// Self-checking bench for sddac_osr: two instances (2nd order OSR=64, and
// 1st order dithered OSR=8) against a tick-level arithmetic reference model.
module tb_sddac_osr;

    localparam int  IN_W = 16;
    localparam longint FS = 64'sd1 <<< (IN_W - 1);

    logic clk = 1'b0;
    logic rst;
    logic en;
    logic in_valid;
    logic [IN_W-1:0] in_data;
    logic clr_flags;

    logic rdy_a, sd_a, ovl_a, ur_a;
    logic rdy_b, sd_b, ovl_b, ur_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sddac_osr #(.IN_W(IN_W), .ORDER(2), .OSR(64), .DITHER_EN(0)) u_a (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
        .in_data(in_data), .in_ready(rdy_a), .sd_out(sd_a),
        .clr_flags(clr_flags), .overload(ovl_a), .underrun(ur_a)
    );

    sddac_osr #(.IN_W(IN_W), .ORDER(1), .OSR(8), .DITHER_EN(1)) u_b (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
        .in_data(in_data), .in_ready(rdy_b), .sd_out(sd_b),
        .clr_flags(clr_flags), .overload(ovl_b), .underrun(ur_b)
    );

    // Reference model state, one slot per instance.
    int     ord [2] = '{2, 1};
    int     osrv[2] = '{64, 8};
    bit     dith[2] = '{1'b0, 1'b1};
    int     m_cnt [2];
    bit     m_full[2];
    longint m_buf [2];
    longint m_cur [2];
    longint m_s1  [2];
    longint m_s2  [2];
    bit [15:0] m_lf[2];
    bit     m_sd [2];
    bit     m_ov [2];
    bit     m_ur [2];

    task automatic chk(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint clampv(input longint v, input int bits);
        longint mx;
        mx = (64'sd1 <<< (bits - 1)) - 1;
        if (v > mx) return mx;
        if (v < -mx - 1) return -mx - 1;
        return v;
    endfunction

    function automatic bit m_ready(input int k);
        return !m_full[k] || (en && m_cnt[k] == osrv[k] - 1);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_full[k] = 0; m_buf[k] = 0; m_cur[k] = 0;
            m_s1[k] = 0; m_s2[k] = 0; m_lf[k] = 16'hACE1;
            m_sd[k] = 0; m_ov[k] = 0; m_ur[k] = 0;
        end
    endtask

    // One clock edge worth of behaviour, from the written rules.
    task automatic model_step(input int k);
        bit cons, acc, q, so, su;
        longint fb, x, n1, n2, c1, c2;
        cons = en && (m_cnt[k] == osrv[k] - 1);
        acc  = in_valid && (!m_full[k] || cons);
        so   = 0;
        su   = 0;
        if (en) begin
            q  = (ord[k] == 2) ? (m_s2[k] >= 0) : (m_s1[k] >= 0);
            fb = q ? FS : -FS;
            x  = m_cur[k];
            if (dith[k]) x = x + (m_lf[k][0] ? 1 : -1);
            n1 = m_s1[k] + x - fb;
            n2 = m_s2[k] + m_s1[k] - 2 * fb;
            c1 = clampv(n1, IN_W + 2);
            if (c1 != n1) so = 1;
            if (ord[k] == 2) begin
                c2 = clampv(n2, IN_W + 4);
                if (c2 != n2) so = 1;
                m_s2[k] = c2;
            end
            m_s1[k]  = c1;
            m_sd[k]  = q;
            m_lf[k]  = {^(m_lf[k] & 16'h002D), m_lf[k][15:1]};
            m_cnt[k] = (m_cnt[k] + 1) % osrv[k];
        end
        if (cons) begin
            if (m_full[k]) m_cur[k] = m_buf[k];
            else su = 1;
        end
        if (acc) begin
            m_full[k] = 1;
            m_buf[k]  = longint'($signed(in_data));
        end else if (cons) begin
            m_full[k] = 0;
        end
        m_ov[k] = so || (m_ov[k] && !clr_flags);
        m_ur[k] = su || (m_ur[k] && !clr_flags);
    endtask

    task automatic compare_all();
        chk("sd_a", sd_a, m_sd[0]);
        chk("rdy_a", rdy_a, m_ready(0));
        chk("ovl_a", ovl_a, m_ov[0]);
        chk("ur_a", ur_a, m_ur[0]);
        chk("sd_b", sd_b, m_sd[1]);
        chk("rdy_b", rdy_b, m_ready(1));
        chk("ovl_b", ovl_b, m_ov[1]);
        chk("ur_b", ur_b, m_ur[1]);
    endtask

    // Called at a falling edge; drives inputs, steps model, checks.
    task automatic tick(input bit e, input bit v,
                        input logic [IN_W-1:0] d, input bit c);
        en = e; in_valid = v; in_data = d; clr_flags = c;
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        compare_all();
    endtask

    // Asynchronous reset away from any edge; outputs must react at once.
    task automatic do_reset();
        en = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("rst_sd_a", sd_a, 0);
        chk("rst_rdy_a", rdy_a, 1);
        chk("rst_ovl_a", ovl_a, 0);
        chk("rst_ur_a", ur_a, 0);
        chk("rst_sd_b", sd_b, 0);
        chk("rst_rdy_b", rdy_b, 1);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic dc_run(input logic [IN_W-1:0] d, input int warm,
                          input int n, output int ones_a, output int ones_b);
        ones_a = 0;
        ones_b = 0;
        for (int i = 0; i < warm; i++) tick(1, 1, d, 0);
        for (int i = 0; i < n; i++) begin
            tick(1, 1, d, 0);
            ones_a += int'(sd_a);
            ones_b += int'(sd_b);
        end
    endtask

    function automatic int clip_to(input int v, input int lo, input int hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    initial begin
        int oa, ob, waits, mism, guard;
        bit e;
        bit q1[$];
        bit q2[$];

        rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = '0; clr_flags = 1'b0;
        model_reset();
        @(negedge clk);
        chk("init_rdy_a", rdy_a, 1);
        chk("init_sd_a", sd_a, 0);
        @(negedge clk);
        rst = 1'b0;

        // DC levels: mid-scale, +half, -half.
        dc_run(16'h0000, 512, 1024, oa, ob);
        chk("dc0_a", oa, clip_to(oa, 508, 516));
        chk("dc0_b", ob, clip_to(ob, 508, 516));
        chk("dc0_ovl_a", ovl_a, 0);
        do_reset();
        dc_run(16'h4000, 512, 1024, oa, ob);
        chk("dcp_a", oa, clip_to(oa, 764, 772));
        chk("dcp_b", ob, clip_to(ob, 764, 772));
        do_reset();
        dc_run(16'hC000, 512, 1024, oa, ob);
        chk("dcn_a", oa, clip_to(oa, 252, 260));
        chk("dcn_b", ob, clip_to(ob, 252, 260));

        // Near full scale: integrators pin, output nearly all ones.
        dc_run(16'h7FFF, 256, 4096, oa, ob);
        chk("fs_a", oa, (oa < 4080) ? 4080 : oa);

        // Underrun: one sample, then starve instance A.
        do_reset();
        tick(1, 1, 16'h1234, 0);
        for (int i = 2; i <= 128; i++) begin
            tick(1, 0, 16'h0000, 0);
            if (i == 64) chk("ur_first", ur_a, 0);
        end
        chk("ur_second", ur_a, 1);
        tick(1, 0, 16'h0000, 1);
        chk("ur_clr", ur_a, 0);

        // Back-to-back samples offered with osr_cnt at 10.
        do_reset();
        guard = 0;
        while (m_cnt[0] != 10 && guard < 200) begin
            tick(1, 0, 16'h0000, 0);
            guard++;
        end
        chk("hs_reach", m_cnt[0], 10);
        tick(1, 1, 16'h0AAA, 0);
        chk("hs_first", rdy_a, 0);
        waits = 0;
        while (!rdy_a && waits < 200) begin
            tick(1, 1, 16'h0555, 0);
            waits++;
        end
        chk("hs_waits", waits, 52);
        tick(1, 1, 16'h0555, 0);
        chk("hs_second", rdy_a, 0);

        // Gated ticks must give the same bitstream, just stretched.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            tick(1, 1, 16'h2345, 0);
            q1.push_back(sd_a);
        end
        do_reset();
        guard = 0;
        while (q2.size() < 300 && guard < 3000) begin
            e = 1'($urandom_range(0, 1));
            tick(e, 1, 16'h2345, 0);
            if (e) q2.push_back(sd_a);
            guard++;
        end
        chk("gate_len", q2.size(), 300);
        mism = 0;
        for (int i = 0; i < q2.size(); i++) if (q1[i] != q2[i]) mism++;
        chk("gate_seq", mism, 0);

        // Random traffic, including an asynchronous reset mid-stream.
        for (int i = 0; i < 2500; i++) begin
            if (i == 1200) do_reset();
            tick(($urandom % 2) == 0, ($urandom % 10) < 7,
                 IN_W'($urandom), ($urandom % 20) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sddac_osr.md
SDDAC_OSR -- requirements
Module: sddac_osr

Interface
REQ-001 Parameter IN_W, default 16, signed input sample width, Q(1,IN_W-1), legal range 8..24.
REQ-002 Parameter ORDER, default 2, modulator order, legal values 1 or 2.
REQ-003 Parameter OSR, default 64, modulator ticks per input sample, legal range 2..1024.
REQ-004 Parameter DITHER_EN, default 0, 1 = add LFSR dither at the first-integrator input.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 en  input  1  modulator tick enable; en=0 freezes all state except the input handshake.
REQ-008 in_valid  input  1  in_data valid.
REQ-009 in_data  input  IN_W  signed sample.
REQ-010 in_ready  output  1  sample buffer can accept.
REQ-011 sd_out  output  1  registered 1-bit modulator output; 1 = +FS.
REQ-012 clr_flags  input  1  clears sticky flags.
REQ-013 overload  output  1  sticky; an integrator saturated.
REQ-014 underrun  output  1  sticky; no buffered sample at a sample boundary.

Function
REQ-015 A 1-deep sample buffer SHALL accept in_data when in_valid && in_ready; in_ready = !buf_full || consume.
REQ-016 osr_cnt SHALL count 0..OSR-1 on each en tick and wrap to 0; consume = en && osr_cnt==OSR-1.
REQ-017 On consume with buf_full: cur_sample <= buffer, buffer empties unless refilled in the same cycle (simultaneous accept+consume keeps buf_full=1 with the new data).
REQ-018 On consume with buffer empty: cur_sample unchanged (sample repeated), underrun set.
REQ-019 FS = 2^(IN_W-1); q = 1 when last-stage integrator >= 0, else 0; fb = q ? +FS : -FS, with q taken from the current integrator state.
REQ-020 Integrators SHALL be signed: s1 IN_W+2 bits, s2 IN_W+4 bits.
REQ-021 ORDER=2, per en tick: s1 <= sat(s1 + x - fb); s2 <= sat(s2 + s1 - 2*fb); q from s2.
REQ-022 ORDER=1, per en tick: s1 <= sat(s1 + x - fb); q from s1; s2 unused, held at 0.
REQ-023 x = cur_sample, plus d in {-1,+1} LSB when DITHER_EN=1, d = lfsr[0] ? +1 : -1.
REQ-024 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 0xACE1; shifts once per en tick.
REQ-025 sat() SHALL clamp to the integrator's own min/max instead of wrapping; any clamp sets overload.
REQ-026 sd_out <= q on each en tick, i.e. one cycle after the integrator state that produced q.
REQ-027 Latency: a sample accepted before consume drives x from the tick after consume; first sd_out influence 1 tick later (ORDER=1) or 2 ticks later (ORDER=2).
REQ-028 clr_flags SHALL clear overload/underrun next edge; a set in the same cycle wins.
REQ-029 en=0: osr_cnt, integrators, LFSR, sd_out, cur_sample hold; buffer still accepts.

Reset
REQ-030 rst=1 SHALL immediately clear s1, s2, osr_cnt, cur_sample, buffer (empty), sd_out=0, overload=0, underrun=0, set LFSR=0xACE1, in_ready=1; mid-operation reset discards the buffered sample.

Verification
REQ-031 Reset: assert rst mid-stream, en=1 -> outputs at reset values without a clock edge; first tick after release matches a golden model from zero state.
REQ-032 DC 0x0000, IN_W=16, ORDER=2, OSR=64, samples always valid -> ones count over any 1024 ticks = 512±4, overload=0.
REQ-033 DC 0x4000 -> ones over 1024 ticks = 768±4; DC 0xC000 -> 256±4; ORDER=1 same bounds.
REQ-034 Feed one sample then hold in_valid=0 -> underrun=1 at the second consume, cur_sample repeated; clr_flags -> underrun=0 next cycle.
REQ-035 Two back-to-back valid samples with osr_cnt=10 -> first accepted, in_ready=0 until consume, second accepted on the consume cycle.
REQ-036 DC 0x7FFF, ORDER=2, 4096 ticks -> overload may set, s1/s2 never wrap sign, sd_out ones >= 4080; en toggled 50% -> sequence identical to en=1 run with ticks compressed.
